// File: rtl/edge_event_arbiter.sv
`default_nettype none
// edge_event_arbiter: captures falling edges on N_CH inputs and issues them one at a time,
// round-robin, as a PULSE_LEN-cycle channel-tagged pulse followed by a GAP_LEN idle gap.
module edge_event_arbiter #(
  parameter int N_CH      = 4,
  parameter int CH_W      = 2,
  parameter int CNT_W     = 5,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sig_in,
  input  logic            clr_overflow,
  output logic            pulse_out,
  output logic [CH_W-1:0] pulse_ch,
  output logic            busy,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_INIT = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_INIT   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [CH_W-1:0]  LAST_INIT  = CH_W'(N_CH - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              pulse_nxt, busy_nxt;
  logic [CH_W-1:0]   ch_nxt, last_grant, last_nxt;

  // hist_new is the most recent sample of sig_in, hist_old the one before it
  logic [N_CH-1:0]   hist_new, hist_old;
  logic [N_CH-1:0]   edge_det;
  logic [N_CH-1:0]   granted, pending_nxt, ovf_set, overflow_nxt;

  logic              found;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_fire;

  assign edge_det = hist_old & ~hist_new;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= N_CH; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!found && pending[c] && (c == ((int'(last_grant) + i) % N_CH))) begin
          found     = 1'b1;
          grant_idx = CH_W'(c);
        end
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign granted[c] = grant_fire && (grant_idx == CH_W'(c));
    // An edge landing on the grant cycle re-arms the channel instead of being lost.
    assign pending_nxt[c] = granted[c] ? edge_det[c] : (pending[c] | edge_det[c]);
    assign ovf_set[c]     = edge_det[c] & pending[c] & ~granted[c];
  end

  assign overflow_nxt = (overflow & ~{N_CH{clr_overflow}}) | ovf_set;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_new <= '0;
      hist_old <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      hist_new <= sig_in;
      hist_old <= hist_new;
      pending  <= pending_nxt;
      overflow <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pulse_nxt  = pulse_out;
    busy_nxt   = busy;
    ch_nxt     = pulse_ch;
    last_nxt   = last_grant;
    grant_fire = 1'b0;
    unique case (state)
      IDLE: begin
        pulse_nxt = 1'b0;
        if (found) begin
          grant_fire = 1'b1;
          ch_nxt     = grant_idx;
          last_nxt   = grant_idx;
          pulse_nxt  = 1'b1;
          busy_nxt   = 1'b1;
          cnt_nxt    = PULSE_INIT;
          state_nxt  = PULSE;
        end
      end
      PULSE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          pulse_nxt = 1'b0;
          if (GAP_LEN == 0) begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = GAP_INIT;
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        pulse_nxt = 1'b0;
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        pulse_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pulse_out  <= 1'b0;
      busy       <= 1'b0;
      pulse_ch   <= '0;
      last_grant <= LAST_INIT;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pulse_out  <= pulse_nxt;
      busy       <= busy_nxt;
      pulse_ch   <= ch_nxt;
      last_grant <= last_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// Scoreboard bench for edge_event_arbiter: stimulus queues expected pulses, a monitor
// checks channel, length and spacing of every pulse the DUT emits.
module tb_edge_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] sig_in;
  logic       clr_overflow;
  logic       pulse_out;
  logic [1:0] pulse_ch;
  logic       busy;
  logic [3:0] pending;
  logic [3:0] overflow;

  edge_event_arbiter #(
    .N_CH(4), .CH_W(2), .CNT_W(5), .PULSE_LEN(4), .GAP_LEN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .clr_overflow(clr_overflow),
    .pulse_out(pulse_out), .pulse_ch(pulse_ch), .busy(busy),
    .pending(pending), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int space;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int ch, input int space);
    exp_t e;
    e.ch    = ch;
    e.space = space;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input logic [3:0] s);
    sig_in = s;
    rst_n  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || pulse_out || pending != 4'h0) && n < 200) begin
      step();
      n++;
    end
    chk({name, "_idle_reached"}, int'(n < 200), 1);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  int   cyc = 0;
  int   last_rise = 0;
  int   plen = 0;
  logic prev_pulse = 1'b0;
  logic aborted = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (pulse_out === 1'b1 && prev_pulse == 1'b0) begin
      plen    = 1;
      aborted = !rst_n;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse_ch", int'(pulse_ch), -1);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_ch", int'(pulse_ch), e.ch);
        if (e.space != 0) chk("rise_spacing", cyc - last_rise, e.space);
      end
      last_rise = cyc;
    end else if (pulse_out === 1'b1) begin
      plen++;
      if (!rst_n) aborted = 1'b1;
    end else if (prev_pulse == 1'b1 && !aborted) begin
      chk("pulse_len", plen, 4);
    end
    prev_pulse = (pulse_out === 1'b1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    sig_in       = 4'hF;
    clr_overflow = 1'b0;
    step();
    step();
    chk("rst_pulse_out", int'(pulse_out), 0);
    chk("rst_pulse_ch", int'(pulse_ch), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overflow", int'(overflow), 0);

    // Level low from reset is not an event; a rising edge is not one either.
    do_reset(4'b1011);
    step();
    step();
    chk("lowfromrst_pending", int'(pending), 0);
    sig_in = 4'hF;
    step();
    step();
    chk("rise_pending", int'(pending), 0);
    chk("rise_pulse_out", int'(pulse_out), 0);

    // Single ch2 event.
    do_reset(4'hF);
    expect_pulse(2, 0);
    sig_in = 4'b1011;
    step();
    sig_in = 4'hF;
    step();
    chk("t1_pending_e1", int'(pending), 'h4);
    step();
    chk("t1_pulse_e2", int'(pulse_out), 1);
    chk("t1_ch_e2", int'(pulse_ch), 2);
    chk("t1_busy_e2", int'(busy), 1);
    chk("t1_pending_e2", int'(pending), 0);
    wait_idle("t1");
    chk("t1_ch_hold", int'(pulse_ch), 2);
    chk("t1_overflow", int'(overflow), 0);

    // Three simultaneous events, served 0,1,3.
    do_reset(4'hF);
    expect_pulse(0, 0);
    expect_pulse(1, 6);
    expect_pulse(3, 6);
    sig_in = 4'b0100;
    step();
    sig_in = 4'hF;
    step();
    chk("t2_pending_e1", int'(pending), 'hB);
    step();
    chk("t2_pending_e2", int'(pending), 'hA);
    repeat (6) step();
    chk("t2_pending_e8", int'(pending), 'h8);
    chk("t2_ch_e8", int'(pulse_ch), 1);
    repeat (6) step();
    chk("t2_pending_e14", int'(pending), 0);
    chk("t2_ch_e14", int'(pulse_ch), 3);
    wait_idle("t2");

    // After a ch1 grant, ch0 and ch1 pending: ch0 wins.
    do_reset(4'hF);
    expect_pulse(1, 0);
    expect_pulse(0, 6);
    expect_pulse(1, 6);
    sig_in = 4'b1101;
    step();
    sig_in = 4'hF;
    step();
    step();
    chk("t3_ch_e2", int'(pulse_ch), 1);
    sig_in = 4'b1100;
    step();
    sig_in = 4'hF;
    step();
    chk("t3_pending", int'(pending), 'h3);
    wait_idle("t3");
    chk("t3_overflow", int'(overflow), 0);

    // Overflow, clear strobe, and clear colliding with a new overflow.
    do_reset(4'hF);
    expect_pulse(0, 0);
    expect_pulse(1, 6);
    expect_pulse(2, 6);
    sig_in = 4'b1110;
    step();
    sig_in = 4'hF;
    step();
    step();
    sig_in = 4'b1101;
    step();
    sig_in = 4'hF;
    step();
    chk("t4_pending_e4", int'(pending), 'h2);
    chk("t4_overflow_e4", int'(overflow), 0);
    sig_in = 4'b1101;
    step();
    sig_in = 4'hF;
    step();
    chk("t4_overflow_e6", int'(overflow), 'h2);
    chk("t4_pending_e6", int'(pending), 'h2);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("t4_overflow_clr", int'(overflow), 0);
    sig_in = 4'b1011;
    step();
    chk("t4_ch_e8", int'(pulse_ch), 1);
    sig_in = 4'hF;
    step();
    sig_in = 4'b1011;
    step();
    sig_in = 4'hF;
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("t4_overflow_setwins", int'(overflow), 'h4);
    chk("t4_pending_e11", int'(pending), 'h4);
    wait_idle("t4");
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("t4_overflow_final", int'(overflow), 0);

    // ch3 edge on its own grant cycle re-arms it without overflow.
    do_reset(4'hF);
    expect_pulse(0, 0);
    expect_pulse(3, 6);
    expect_pulse(3, 6);
    sig_in = 4'b0110;
    step();
    sig_in = 4'hF;
    step();
    chk("t5_pending_e1", int'(pending), 'h9);
    step();
    repeat (4) step();
    sig_in = 4'b0111;
    step();
    sig_in = 4'hF;
    step();
    chk("t5_ch_e8", int'(pulse_ch), 3);
    chk("t5_pending_e8", int'(pending), 'h8);
    chk("t5_overflow_e8", int'(overflow), 0);
    wait_idle("t5");
    chk("t5_overflow", int'(overflow), 0);

    // Reset in the middle of a pulse with ch1 pending.
    do_reset(4'hF);
    expect_pulse(0, 0);
    sig_in = 4'b1100;
    step();
    sig_in = 4'hF;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("t6_pulse_out", int'(pulse_out), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_pending", int'(pending), 0);
    chk("t6_pulse_ch", int'(pulse_ch), 0);
    rst_n = 1'b1;
    step();
    step();
    chk("t6_queue_after_rst", exp_q.size(), 0);
    expect_pulse(0, 0);
    expect_pulse(1, 6);
    sig_in = 4'b1100;
    step();
    sig_in = 4'hF;
    step();
    wait_idle("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
